// File: rtl/sram_responder.sv
// sram_responder
//   On-chip stand-in for the SLC-3 external SRAM. Bus controls are active-low.
//   After reset it preloads words 0..INIT_WORDS-1 with 16'hA500 | index.
//   Reads return data a fixed READ_LATENCY edges after the request edge.
//   Writes commit the byte lanes selected by UB/LB.
//   Address bits above DEPTH_BITS are ignored, so higher addresses alias
//   onto the implemented words.
// Ports
//   Clk      system clock; all state changes on the rising edge
//   Reset    asynchronous, active-high
//   CE/UB/LB/OE/WE  active-low chip, byte-lane, output and write enables
//   ADDR     20-bit word address
//   Data     16-bit bidirectional bus; driven only while read data is valid
//   Busy     high while the preload is running; bus requests are ignored
//   RdValid  high while Data carries valid read data
module sram_responder #(
  parameter int DEPTH_BITS   = 10,
  parameter int READ_LATENCY = 2,
  parameter int INIT_WORDS   = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        CE,
  input  logic        UB,
  input  logic        LB,
  input  logic        OE,
  input  logic        WE,
  input  logic [19:0] ADDR,
  inout  logic [15:0] Data,
  output logic        Busy,
  output logic        RdValid
);

  localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [CW-1:0]         CNT_LOAD = CW'(READ_LATENCY - 1);
  localparam logic [DEPTH_BITS-1:0] LAST_IDX = DEPTH_BITS'(INIT_WORDS - 1);

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_READ,
    S_WRITE
  } state_t;

  state_t                state, state_n;
  logic [DEPTH_BITS-1:0] idx, idx_n;
  logic [19:0]           raddr, raddr_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic                  valid, valid_n;
  logic                  capture;

  logic [15:0]           mem [2**DEPTH_BITS];
  logic [15:0]           rdata;

  logic                  mem_we;
  logic [DEPTH_BITS-1:0] mem_waddr;
  logic [15:0]           mem_wdata;
  logic [1:0]            mem_wmask;
  logic                  drv_hi, drv_lo;

  logic wr_req, rd_req;
  assign wr_req = ~CE & ~WE;
  assign rd_req = ~CE & ~OE & WE;

  // State register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= S_INIT;
      idx   <= '0;
      raddr <= '0;
      cnt   <= '0;
      valid <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      raddr <= raddr_n;
      cnt   <= cnt_n;
      valid <= valid_n;
    end
  end

  // Next-state logic. Any path out of READ leaves valid_n low, so RdValid and
  // the Data drivers drop on the same edge that ends the read.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    raddr_n = raddr;
    cnt_n   = cnt;
    valid_n = 1'b0;
    capture = 1'b0;
    unique case (state)
      S_INIT: begin
        idx_n = idx + 1'b1;
        if (idx == LAST_IDX) begin
          state_n = S_IDLE;
          idx_n   = '0;
        end
      end
      S_IDLE: begin
        if (wr_req) begin
          state_n = S_WRITE;
        end else if (rd_req) begin
          state_n = S_READ;
          raddr_n = ADDR;
          cnt_n   = CNT_LOAD;
        end
      end
      S_WRITE: begin
        if (!wr_req) state_n = S_IDLE;
      end
      S_READ: begin
        if (wr_req) begin
          state_n = S_WRITE;
        end else if (CE || OE) begin
          state_n = S_IDLE;
        end else if (ADDR != raddr) begin
          // A new address restarts the full latency.
          raddr_n = ADDR;
          cnt_n   = CNT_LOAD;
        end else if (cnt == '0) begin
          capture = 1'b1;
          valid_n = 1'b1;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: state_n = S_INIT;
    endcase
  end

  // Outputs and memory write port. Outside INIT, every edge with CE and WE
  // low commits a write, whichever state it starts from.
  // Drivers are gated combinationally by WE so the bus is released in the
  // same cycle the initiator starts a write.
  always_comb begin
    Busy      = (state == S_INIT);
    RdValid   = valid;
    drv_hi    = valid & WE & ~UB;
    drv_lo    = valid & WE & ~LB;
    mem_we    = 1'b0;
    mem_waddr = ADDR[DEPTH_BITS-1:0];
    mem_wdata = Data;
    mem_wmask = {~UB, ~LB};
    if (state == S_INIT) begin
      mem_we    = 1'b1;
      mem_waddr = idx;
      mem_wdata = 16'hA500 | 16'(idx);
      mem_wmask = 2'b11;
    end else if (wr_req) begin
      mem_we = 1'b1;
    end
  end

  // Memory array and read register. Neither is reset.
  always_ff @(posedge Clk) begin
    if (mem_we) begin
      if (mem_wmask[1]) mem[mem_waddr][15:8] <= mem_wdata[15:8];
      if (mem_wmask[0]) mem[mem_waddr][7:0]  <= mem_wdata[7:0];
    end
    if (capture) rdata <= mem[raddr[DEPTH_BITS-1:0]];
  end

  assign Data[15:8] = drv_hi ? rdata[15:8] : 8'hzz;
  assign Data[7:0]  = drv_lo ? rdata[7:0]  : 8'hzz;

endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder
//   Directed bench for sram_responder. Data carries pull-ups, so a released
//   byte lane reads back as 8'hFF.
module tb_sram_responder;

  logic        Clk, Reset, CE, UB, LB, OE, WE;
  logic [19:0] ADDR;
  wire  [15:0] Data;
  logic        Busy, RdValid;
  logic        tb_drv;
  logic [15:0] tb_data;

  localparam logic [15:0] ZBUS = 16'hFFFF;

  int checks = 0;
  int errors = 0;

  assign Data = tb_drv ? tb_data : 16'hzzzz;

  for (genvar g = 0; g < 16; g++) begin : g_pu
    pullup (Data[g]);
  end

  sram_responder #(.DEPTH_BITS(10), .READ_LATENCY(2), .INIT_WORDS(16)) dut (
    .Clk(Clk), .Reset(Reset), .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE),
    .ADDR(ADDR), .Data(Data), .Busy(Busy), .RdValid(RdValid)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic bus_idle;
    CE = 1'b1; OE = 1'b1; WE = 1'b1; UB = 1'b1; LB = 1'b1; tb_drv = 1'b0;
  endtask

  task automatic wr(input logic [19:0] a, input logic [15:0] d, input logic ub, input logic lb);
    CE = 1'b0; WE = 1'b0; OE = 1'b1; UB = ub; LB = lb; ADDR = a;
    tb_data = d; tb_drv = 1'b1;
    tick;
    chk("wr_rdvalid", 16'(RdValid), 16'h0);
    bus_idle;
    tick;
  endtask

  task automatic rd_chk(input string tag, input logic [19:0] a, input logic ub,
                        input logic lb, input logic [15:0] exp);
    CE = 1'b0; OE = 1'b0; WE = 1'b1; UB = ub; LB = lb; ADDR = a;
    tick;
    chk({tag, "_rdv0"}, 16'(RdValid), 16'h0);
    tick;
    chk({tag, "_rdv1"}, 16'(RdValid), 16'h0);
    chk({tag, "_z1"}, Data, ZBUS);
    tick;
    chk({tag, "_rdv2"}, 16'(RdValid), 16'h1);
    chk({tag, "_data"}, Data, exp);
    bus_idle;
    tick;
    chk({tag, "_end"}, 16'(RdValid), 16'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    Reset = 1'b1; ADDR = '0; tb_data = '0;
    bus_idle;
    repeat (3) tick;
    chk("busy_in_reset", 16'(Busy), 16'h1);
    chk("rdv_in_reset", 16'(RdValid), 16'h0);

    // Preload: Busy for exactly 16 cycles, bus released throughout
    Reset = 1'b0;
    chk("busy_release", 16'(Busy), 16'h1);
    for (int i = 1; i <= 16; i++) begin
      tick;
      chk("init_busy", 16'(Busy), (i < 16) ? 16'h1 : 16'h0);
      chk("init_z", Data, ZBUS);
    end

    // Preloaded word, fixed latency
    rd_chk("rd3", 20'h00003, 1'b0, 1'b0, 16'hA503);
    rd_chk("rd15", 20'h0000F, 1'b0, 1'b0, 16'hA50F);

    // Byte-lane reads
    rd_chk("lane_lo", 20'h00003, 1'b1, 1'b0, 16'hFF03);
    rd_chk("lane_hi", 20'h00003, 1'b0, 1'b1, 16'hA5FF);

    // Byte-lane writes
    wr(20'h00020, 16'h1234, 1'b0, 1'b0);
    rd_chk("wr_full", 20'h00020, 1'b0, 1'b0, 16'h1234);
    wr(20'h00020, 16'hFFFF, 1'b1, 1'b0);
    rd_chk("wr_lo", 20'h00020, 1'b0, 1'b0, 16'h12FF);
    wr(20'h00020, 16'h0000, 1'b1, 1'b1);
    rd_chk("wr_none", 20'h00020, 1'b0, 1'b0, 16'h12FF);

    // Address change mid-read restarts the latency
    CE = 1'b0; OE = 1'b0; WE = 1'b1; UB = 1'b0; LB = 1'b0; ADDR = 20'h00005;
    tick;
    ADDR = 20'h00006;
    tick;
    chk("chg_rdv0", 16'(RdValid), 16'h0);
    chk("chg_z0", Data, ZBUS);
    tick;
    chk("chg_rdv1", 16'(RdValid), 16'h0);
    tick;
    chk("chg_rdv2", 16'(RdValid), 16'h1);
    chk("chg_data6", Data, 16'hA506);
    ADDR = 20'h00007;
    tick;
    chk("chg2_rdv0", 16'(RdValid), 16'h0);
    chk("chg2_z0", Data, ZBUS);
    tick;
    tick;
    chk("chg2_data7", Data, 16'hA507);
    bus_idle;
    tick;
    chk("chg_end", 16'(RdValid), 16'h0);

    // WE while data is driven: bus released in the same cycle
    CE = 1'b0; OE = 1'b0; WE = 1'b1; UB = 1'b0; LB = 1'b0; ADDR = 20'h00003;
    repeat (3) tick;
    chk("rw_data", Data, 16'hA503);
    WE = 1'b0;
    #1;
    chk("rw_release", Data, ZBUS);
    bus_idle;
    tick;
    chk("rw_rdv", 16'(RdValid), 16'h0);
    rd_chk("rw_intact", 20'h00003, 1'b0, 1'b0, 16'hA503);

    // OE and WE both low is a write; upper address bits alias
    CE = 1'b0; OE = 1'b0; WE = 1'b0; UB = 1'b0; LB = 1'b0; ADDR = 20'h00400;
    tb_data = 16'hBEEF; tb_drv = 1'b1;
    tick;
    chk("oewe_rdv", 16'(RdValid), 16'h0);
    tb_drv = 1'b0;
    #1;
    chk("oewe_nodrive", Data, ZBUS);
    bus_idle;
    tick;
    rd_chk("alias0", 20'h00000, 1'b0, 1'b0, 16'hBEEF);
    rd_chk("alias400", 20'h00400, 1'b0, 1'b0, 16'hBEEF);

    // Reset while driving: immediate release, then re-preload
    CE = 1'b0; OE = 1'b0; WE = 1'b1; UB = 1'b0; LB = 1'b0; ADDR = 20'h00004;
    repeat (3) tick;
    chk("prerst_data", Data, 16'hA504);
    #2 Reset = 1'b1;
    #1;
    chk("rst_z", Data, ZBUS);
    chk("rst_rdv", 16'(RdValid), 16'h0);
    chk("rst_busy", 16'(Busy), 16'h1);
    bus_idle;
    tick;
    Reset = 1'b0;
    repeat (15) tick;
    chk("reinit_busy", 16'(Busy), 16'h1);
    tick;
    chk("reinit_done", 16'(Busy), 16'h0);
    rd_chk("reinit0", 20'h00000, 1'b0, 1'b0, 16'hA500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
